// File: rtl/alu_pkg.sv
// Shared opcode encodings, opcode enum and flag bundle for the pipelined ALU.
package alu_pkg;

    localparam logic [2:0] OPC_ADD = 3'b000;
    localparam logic [2:0] OPC_SUB = 3'b001;
    localparam logic [2:0] OPC_AND = 3'b010;
    localparam logic [2:0] OPC_OR  = 3'b011;
    localparam logic [2:0] OPC_XOR = 3'b100;
    localparam logic [2:0] OPC_SHL = 3'b101;
    localparam logic [2:0] OPC_SHR = 3'b110;
    localparam logic [2:0] OPC_MUL = 3'b111;

    typedef enum logic [2:0] {
        OP_ADD = OPC_ADD,
        OP_SUB = OPC_SUB,
        OP_AND = OPC_AND,
        OP_OR  = OPC_OR,
        OP_XOR = OPC_XOR,
        OP_SHL = OPC_SHL,
        OP_SHR = OPC_SHR,
        OP_MUL = OPC_MUL
    } opcode_e;

    typedef struct packed {
        logic c;
        logic z;
        logic v;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// result held in DONE until acknowledged.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    input  logic               ack,
    output logic [2*WIDTH-1:0] product
);
    import alu_pkg::*;

    localparam int unsigned      CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

    state_e               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_BUSY: begin
                    if (r_mplier[0])
                        r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: ;
            endcase
            // A new multiply may be accepted in the same cycle DONE is acknowledged.
            if (start && (r_state == ST_IDLE || (r_state == ST_DONE && ack))) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, a};
                r_mplier <= b;
                r_cnt    <= '0;
                r_state  <= ST_BUSY;
                r_busy   <= 1'b1;
                r_done   <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with carry/zero/overflow/error flags.
// Define ALU_MUL_EN to enable the iterative opcode-111 multiply.
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       OPCODE,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_err
);
    import alu_pkg::*;

    localparam int unsigned SHW = $clog2(WIDTH);

    logic             r_s1_valid;
    opcode_e          r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    flags_t           r_flags;

    logic             w_accept;
    logic             w_s1_done;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_res;
    flags_t           w_flags;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [SHW-1:0]   w_shamt;

`ifdef ALU_MUL_EN
    logic               w_mul_busy;
    logic               w_mul_done;
    logic               w_mul_start;
    logic [2*WIDTH-1:0] w_product;

    assign w_mul_start = w_accept && (OPCODE == OPC_MUL) && !w_mul_busy;
    assign w_s1_done   = (r_s1_op != OP_MUL) || w_mul_done;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rstn    (rstn),
        .start   (w_mul_start),
        .a       (OP1),
        .b       (OP2),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .ack     (w_s1_adv),
        .product (w_product)
    );
`else
    assign w_s1_done = 1'b1;
`endif

    assign w_accept = in_valid && in_ready;
    assign w_s1_adv = r_s1_valid && w_s1_done && (!r_out_valid || out_ready);
    assign in_ready = !r_s1_valid || w_s1_adv;

    always_comb begin
        w_res   = '0;
        w_flags = '0;
        w_sum   = '0;
        w_shamt = r_s1_b[SHW-1:0];
        // One extra bit on each shift captures the last bit shifted out.
        w_shl   = {1'b0, r_s1_a} << w_shamt;
        w_shr   = {r_s1_a, 1'b0} >> w_shamt;
        case (r_s1_op)
            OP_ADD: begin
                w_sum     = {1'b0, r_s1_a} + {1'b0, r_s1_b};
                w_res     = w_sum[WIDTH-1:0];
                w_flags.c = w_sum[WIDTH];
                w_flags.v = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sum     = {1'b0, r_s1_a} - {1'b0, r_s1_b};
                w_res     = w_sum[WIDTH-1:0];
                w_flags.c = w_sum[WIDTH];
                w_flags.v = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            OP_AND: w_res = r_s1_a & r_s1_b;
            OP_OR:  w_res = r_s1_a | r_s1_b;
            OP_XOR: w_res = r_s1_a ^ r_s1_b;
            OP_SHL: begin
                w_res     = w_shl[WIDTH-1:0];
                w_flags.c = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res     = w_shr[WIDTH:1];
                w_flags.c = w_shr[0];
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                w_res     = w_product[WIDTH-1:0];
                w_flags.v = |w_product[2*WIDTH-1:WIDTH];
`else
                w_flags.err = 1'b1;
`endif
            end
            default: w_flags.err = 1'b1;
        endcase
        w_flags.z = (w_res == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= opcode_e'(OPCODE);
            r_s1_a     <= OP1;
            r_s1_b     <= OP2;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_flags     <= w_flags;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_c    = r_flags.c;
    assign flag_z    = r_flags.z;
    assign flag_v    = r_flags.v;
    assign flag_err  = r_flags.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=4 and WIDTH=8; opcode-111 expectations
// follow ALU_MUL_EN.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;

    logic       a_iv, a_ir, a_ov, a_or, a_c, a_z, a_v, a_e;
    logic [2:0] a_op;
    logic [3:0] a_x, a_y, a_res;

    logic       b_iv, b_ir, b_ov, b_or, b_c, b_z, b_v, b_e;
    logic [2:0] b_op;
    logic [7:0] b_x, b_y, b_res;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .in_valid(a_iv), .in_ready(a_ir), .OPCODE(a_op),
        .OP1(a_x), .OP2(a_y), .out_valid(a_ov), .out_ready(a_or), .result(a_res),
        .flag_c(a_c), .flag_z(a_z), .flag_v(a_v), .flag_err(a_e)
    );

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rstn(rstn), .in_valid(b_iv), .in_ready(b_ir), .OPCODE(b_op),
        .OP1(b_x), .OP2(b_y), .out_valid(b_ov), .out_ready(b_or), .result(b_res),
        .flag_c(b_c), .flag_z(b_z), .flag_v(b_v), .flag_err(b_e)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic ov, input logic [3:0] res,
                        input logic c, input logic z, input logic v, input logic e);
        chk({tag, ".ov"},  a_ov,  ov);
        chk({tag, ".res"}, a_res, res);
        chk({tag, ".c"},   a_c,   c);
        chk({tag, ".z"},   a_z,   z);
        chk({tag, ".v"},   a_v,   v);
        chk({tag, ".err"}, a_e,   e);
    endtask

    task automatic chk8(input string tag, input logic ov, input logic [7:0] res,
                        input logic c, input logic z, input logic v, input logic e);
        chk({tag, ".ov"},  b_ov,  ov);
        chk({tag, ".res"}, b_res, res);
        chk({tag, ".c"},   b_c,   c);
        chk({tag, ".z"},   b_z,   z);
        chk({tag, ".v"},   b_v,   v);
        chk({tag, ".err"}, b_e,   e);
    endtask

    initial begin
        a_iv = 0; a_op = '0; a_x = '0; a_y = '0; a_or = 1;
        b_iv = 0; b_op = '0; b_x = '0; b_y = '0; b_or = 1;

        repeat (2) tick;
        chk4("rst4", 0, 4'h0, 0, 0, 0, 0);
        chk8("rst8", 0, 8'h00, 0, 0, 0, 0);
        rstn = 1;
        tick;
        chk("rel.ir4", a_ir, 1);
        chk("rel.ir8", b_ir, 1);

        // W4 ADD F+F
        a_iv = 1; a_op = 3'b000; a_x = 4'hF; a_y = 4'hF;
        tick;
        a_iv = 0;
        chk("add.lat", a_ov, 0);
        tick;
        chk4("add", 1, 4'hE, 1, 0, 0, 0);
        tick;
        chk("add.drop", a_ov, 0);

        // W4 SUB 3-5 then 8-1, back to back
        a_iv = 1; a_op = 3'b001; a_x = 4'h3; a_y = 4'h5;
        tick;
        a_x = 4'h8; a_y = 4'h1;
        tick;
        a_iv = 0;
        chk4("sub1", 1, 4'hE, 1, 0, 0, 0);
        tick;
        chk4("sub2", 1, 4'h7, 0, 0, 1, 0);
        tick;
        chk("sub.drop", a_ov, 0);

        // W4 opcode 111 with F,F
        a_iv = 1; a_op = 3'b111; a_x = 4'hF; a_y = 4'hF;
        tick;
        a_iv = 0;
`ifdef ALU_MUL_EN
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) chk("mul.busy_ir", a_ir, 0);
            chk("mul.lat", a_ov, 0);
            tick;
        end
        chk4("mul", 1, 4'h1, 0, 0, 1, 0);
        tick;
        chk("mul.drop", a_ov, 0);

        // reset while multiply busy
        a_iv = 1; a_op = 3'b111; a_x = 4'h7; a_y = 4'h3;
        tick;
        a_iv = 0;
        tick;
        tick;
        rstn = 0;
        #1;
        chk4("mulrst", 0, 4'h0, 0, 0, 0, 0);
        rstn = 1;
        tick;
        chk("mulrst.ir", a_ir, 1);
        repeat (8) tick;
        chk("mulrst.stale", a_ov, 0);
`else
        tick;
        chk4("illegal", 1, 4'h0, 0, 1, 0, 1);
        tick;
        chk("illegal.drop", a_ov, 0);
`endif

        // W8 shifts: SHL 81<<1, SHL by 0 (OP2=8 uses low 3 bits), SHR 01>>1
        b_iv = 1; b_op = 3'b101; b_x = 8'h81; b_y = 8'h01;
        tick;
        b_y = 8'h08;
        tick;
        chk8("shl1", 1, 8'h02, 1, 0, 0, 0);
        b_op = 3'b110; b_x = 8'h01; b_y = 8'h01;
        tick;
        b_iv = 0;
        chk8("shl0", 1, 8'h81, 0, 0, 0, 0);
        tick;
        chk8("shr1", 1, 8'h00, 1, 1, 0, 0);

        // W8 ADD signed overflow, then OR
        b_iv = 1; b_op = 3'b000; b_x = 8'h7F; b_y = 8'h01;
        tick;
        b_op = 3'b011; b_x = 8'hA0; b_y = 8'h05;
        tick;
        b_iv = 0;
        chk8("addovf", 1, 8'h80, 0, 0, 1, 0);
        tick;
        chk8("or", 1, 8'hA5, 0, 0, 0, 0);
        tick;
        chk("or.drop", b_ov, 0);

        // W8 back-to-back with consumer stalled
        b_or = 0;
        b_iv = 1; b_op = 3'b000; b_x = 8'h10; b_y = 8'h20;
        tick;
        chk("b2b.ir1", b_ir, 1);
        b_op = 3'b001; b_x = 8'h50; b_y = 8'h10;
        tick;
        chk("b2b.ir_drop", b_ir, 0);
        chk8("b2b.a", 1, 8'h30, 0, 0, 0, 0);
        b_op = 3'b010; b_x = 8'hF0; b_y = 8'h3C;
        tick;
        chk("b2b.ir_stall", b_ir, 0);
        chk8("b2b.frozen", 1, 8'h30, 0, 0, 0, 0);
        b_or = 1;
        #1;
        chk("b2b.ir_resume", b_ir, 1);
        tick;
        chk8("b2b.b", 1, 8'h40, 0, 0, 0, 0);
        b_op = 3'b100; b_x = 8'hFF; b_y = 8'h0F;
        tick;
        b_iv = 0;
        chk8("b2b.c", 1, 8'h30, 0, 0, 0, 0);
        tick;
        chk8("b2b.d", 1, 8'hF0, 0, 0, 0, 0);
        tick;
        chk("b2b.drop", b_ov, 0);

        // reset while result stalled at the output
        b_or = 0;
        b_iv = 1; b_op = 3'b100; b_x = 8'h55; b_y = 8'h0F;
        tick;
        b_iv = 0;
        tick;
        chk8("stall", 1, 8'h5A, 0, 0, 0, 0);
        tick;
        chk8("stall.hold", 1, 8'h5A, 0, 0, 0, 0);
        rstn = 0;
        #1;
        chk8("stallrst", 0, 8'h00, 0, 0, 0, 0);
        rstn = 1;
        tick;
        chk("stallrst.ir", b_ir, 1);
        b_or = 1;
        repeat (3) tick;
        chk("stallrst.stale", b_ov, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the 4-bit single-cycle ALU.
- Operand width is configurable.
- Uses a valid/ready handshake on both input and output, with full backpressure.
- Adds status flags (carry, zero, overflow, err).
- Optional iterative multi-cycle multiply.
- Sits between the operand/issue logic and the writeback/result consumer.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2, power of 2)
- SHW, $clog2(WIDTH), shift-amount width (derived; not to be overridden)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts operation this cycle
- OPCODE  in  3  operation select
- OP1  in  WIDTH  operand 1
- OP2  in  WIDTH  operand 2
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- flag_c  out  1  carry/borrow
- flag_z  out  1  result == 0
- flag_v  out  1  signed overflow (ADD/SUB), upper-half-nonzero (MUL)
- flag_err  out  1  illegal opcode

Behaviour:
Opcodes:
- 000 ADD: {c,result}=OP1+OP2
- 001 SUB: result=OP1-OP2; c=1 iff OP1<OP2 (unsigned borrow)
- 010 AND, 011 OR, 100 XOR: c=0, v=0
- 101 SHL: result=OP1<<OP2[SHW-1:0]; c=last bit shifted out (0 if shift 0)
- 110 SHR logical: same rules as SHL, shifting right
- 111 MUL: see Optional Feature
- v for ADD: sign(OP1)==sign(OP2) && sign(result)!=sign(OP1)
- v for SUB: sign(OP1)!=sign(OP2) && sign(result)!=sign(OP1)
- z computed on the final result for all ops, including err cases

Pipeline:
- Stage S1 captures {OPCODE,OP1,OP2} on in_valid&&in_ready.
- Stage S2 (output register) holds result+flags.
- Latency: 2 clk edges from accept to out_valid for single-cycle ops.
- S1 advances when its op is complete and (!out_valid || out_ready).
- in_ready = !s1_valid || s1_advance (combinational; no bubble at full throughput).
- Throughput: 1 op/cycle when out_ready stays high.
- Output handshake: result/flags stable while out_valid && !out_ready. out_valid drops only after the transfer, unless a new result loads in the same cycle.
- Simultaneous out transfer and S1 advance: S2 is overwritten with the new result, out_valid stays 1.
- in_valid must not be assumed held; an op is only accepted on in_ready.

Reset (async, rstn=0):
- s1_valid=0, out_valid=0, result=0, all flags=0, any multiply aborted.
- in_ready=1 in the first cycle after reset release.
- Reset mid-operation discards all in-flight ops; nothing is emitted afterwards.

Optional Feature:
Macro: ALU_MUL_EN.
- Defined: opcode 111 = unsigned MUL via shift-add FSM.
  - States: IDLE -> BUSY (WIDTH cycles, one partial product per cycle) -> DONE.
  - DONE waits for S2 to be free, then loads result=product[WIDTH-1:0], v=|product[2W-1:W], c=0, err=0.
  - S1 is held (in_ready=0) while BUSY/DONE.
  - Latency: WIDTH+2 cycles from accept to out_valid.
  - Returns to IDLE on transfer into S2.
- Not defined: opcode 111 is illegal and completes in 2 cycles with result=0, z=1, err=1, c=v=0. No FSM or multiplier logic is synthesised.

Decomposition:
- Package alu_pkg:
  - opcode enum (OP_ADD..OP_MUL, 3-bit)
  - flags struct {c,z,v,err}
  - localparams for the opcode encodings
- Sub-module alu_mul_seq:
  - Contains the shift-add FSM.
  - Ports: clk, rstn, start, a, b, busy, done, ack, product[2*WIDTH].
  - Instantiated only under ALU_MUL_EN.
- Combinational op/flag logic stays inline in alu_pipe.

Test Plan:
- WIDTH=4, ADD OP1=F OP2=F, out_ready=1 -> after 2 cycles result=E, c=1, z=0, v=0, err=0.
- WIDTH=4, SUB OP1=3 OP2=5 -> result=E, c=1; then SUB 8-1 -> result=7, v=1, c=0.
- WIDTH=8, back-to-back 4 ops with out_ready held 0 for 3 cycles:
  - in_ready drops after 2 ops accepted.
  - result stays frozen while stalled.
  - all 4 results emerge in order, none lost or duplicated.
- WIDTH=8, SHL OP1=0x81 OP2=1 -> result=0x02, c=1; SHR OP1=0x01 OP2=1 -> result=0x00, c=1, z=1.
- OPCODE=111, OP1=F OP2=F, WIDTH=4:
  - With ALU_MUL_EN: result=1, v=1, out_valid at cycle 6, in_ready=0 during BUSY.
  - Without ALU_MUL_EN: result=0, z=1, err=1 at cycle 2.
- Assert rstn=0 while MUL BUSY or while out_valid=1 & stalled -> all outputs 0 immediately; no stale result after release; in_ready=1.
